// File: rtl/pwm_capture.sv
// Eight-channel PWM input capture: per channel, measures rise-to-rise period and
// rise-to-fall high time in clock cycles, exposed on the 8-bit rd/wr register bus.
module pwm_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic [6:0] adrs,
  output logic [7:0] dout,
  input  logic [7:0] pwmi
);

  localparam logic [6:0] VALID_ADR = 7'h60;
  localparam logic [6:0] OVF_ADR   = 7'h64;

  logic [7:0] s1_r, s2_r, prev_r;
  logic [7:0] en_r, armed_r, valid_r, ovf_r;
  logic [7:0] cnt_r    [8];
  logic [7:0] hcnt_r   [8];
  logic [7:0] period_r [8];
  logic [7:0] high_r   [8];

  logic [7:0] rise_s, fall_s, cap_s, ovf_set_s, ctrl_wr_s;
  logic [7:0] rdata_s;
  logic       valid_clr_s, ovf_clr_s;
  logic       unused_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Channel base is ch*12, built as ch*8 + ch*4 to stay in bus-address width.
  function automatic logic [6:0] reg_adr(input logic [2:0] ch, input logic [6:0] off);
    return {1'b0, ch, 3'b000} + {2'b00, ch, 2'b00} + off;
  endfunction

  // Edge detection, capture/overflow events and register read mux
  always_comb begin
    rdata_s     = 8'h00;
    rise_s      = 8'h00;
    fall_s      = 8'h00;
    cap_s       = 8'h00;
    ovf_set_s   = 8'h00;
    ctrl_wr_s   = 8'h00;
    valid_clr_s = rd & (adrs == VALID_ADR);
    ovf_clr_s   = rd & (adrs == OVF_ADR);
    unused_s    = ^din[7:1];
    for (int n = 0; n < 8; n++) begin
      rise_s[n]    = s2_r[n] & ~prev_r[n];
      fall_s[n]    = ~s2_r[n] & prev_r[n];
      cap_s[n]     = en_r[n] & rise_s[n] & armed_r[n];
      ovf_set_s[n] = en_r[n] & ~rise_s[n] & (cnt_r[n] == 8'd254);
      ctrl_wr_s[n] = wr & (adrs == reg_adr(3'(n), 7'h00));
      rdata_s = rdata_s
              | ((adrs == reg_adr(3'(n), 7'h00)) ? {7'b0000000, en_r[n]} : 8'h00)
              | ((adrs == reg_adr(3'(n), 7'h04)) ? period_r[n] : 8'h00)
              | ((adrs == reg_adr(3'(n), 7'h08)) ? high_r[n] : 8'h00);
    end
    rdata_s = rdata_s
            | ((adrs == VALID_ADR) ? valid_r : 8'h00)
            | ((adrs == OVF_ADR) ? ovf_r : 8'h00);
  end

  // Input synchronizers and per-channel period/high-time measurement
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= 8'h00;
      s2_r    <= 8'h00;
      prev_r  <= 8'h00;
      armed_r <= 8'h00;
      for (int n = 0; n < 8; n++) begin
        cnt_r[n]    <= 8'h00;
        hcnt_r[n]   <= 8'h00;
        period_r[n] <= 8'h00;
        high_r[n]   <= 8'h00;
      end
    end else begin
      s1_r   <= pwmi;
      s2_r   <= s1_r;
      prev_r <= s2_r;
      for (int n = 0; n < 8; n++) begin
        if (!en_r[n]) begin
          cnt_r[n]   <= 8'h00;
          hcnt_r[n]  <= 8'h00;
          armed_r[n] <= 1'b0;
        end else if (rise_s[n]) begin
          // The first rise after enable only arms; later rises close a period.
          cnt_r[n]   <= 8'd1;
          hcnt_r[n]  <= 8'd1;
          armed_r[n] <= 1'b1;
          if (armed_r[n]) begin
            period_r[n] <= cnt_r[n];
          end
        end else begin
          cnt_r[n] <= sat_inc(cnt_r[n]);
          if (s2_r[n]) begin
            hcnt_r[n] <= sat_inc(hcnt_r[n]);
          end
          if (fall_s[n] && armed_r[n]) begin
            high_r[n] <= hcnt_r[n];
          end
        end
      end
    end
  end

  // Bus side: CTRL writes, registered read data, sticky status with set-over-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r    <= 8'h00;
      dout    <= 8'h00;
      valid_r <= 8'h00;
      ovf_r   <= 8'h00;
    end else begin
      en_r    <= (en_r & ~ctrl_wr_s) | (ctrl_wr_s & {8{din[0]}});
      if (rd) begin
        dout <= rdata_s;
      end
      valid_r <= (valid_clr_s ? 8'h00 : valid_r) | cap_s;
      ovf_r   <= (ovf_clr_s ? 8'h00 : ovf_r) | ovf_set_s;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture: register map, capture, overflow,
// read-to-clear races, enable gating and reset.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst, rd, wr;
  logic [7:0] din;
  logic [6:0] adrs;
  logic [7:0] dout;
  logic [7:0] pwmi;

  int errors = 0;
  int checks = 0;

  logic [7:0] lvl;
  logic [7:0] gen_on;
  int per [8];
  int hi  [8];
  int ph  [8];

  pwm_capture dut (
    .clk  (clk),
    .rst  (rst),
    .rd   (rd),
    .wr   (wr),
    .din  (din),
    .adrs (adrs),
    .dout (dout),
    .pwmi (pwmi)
  );

  always #5 clk = ~clk;

  // Waveform source: square wave per channel when enabled, else a manual level.
  initial begin
    pwmi = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 8; n++) begin
        if (gen_on[n]) begin
          pwmi[n] = (ph[n] < hi[n]);
          ph[n] = (ph[n] + 1 >= per[n]) ? 0 : ph[n] + 1;
        end else begin
          pwmi[n] = lvl[n];
        end
      end
    end
  end

  task automatic rd_reg(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    rd = 1'b1;
    adrs = a;
    @(negedge clk);
    rd = 1'b0;
    d = dout;
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] v);
    @(negedge clk);
    wr = 1'b1;
    adrs = a;
    din = v;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic start_gen(input int n, input int p, input int h);
    per[n] = p;
    hi[n] = h;
    ph[n] = 0;
    gen_on[n] = 1'b1;
  endtask

  task automatic pulse(input int n, input int w);
    @(negedge clk);
    lvl[n] = 1'b1;
    repeat (w) @(negedge clk);
    lvl[n] = 1'b0;
  endtask

  task automatic drain();
    logic [7:0] d;
    rd_reg(7'h60, d);
    rd_reg(7'h64, d);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [6:0] a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_dout: got %h expected 00", dout);
    end
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) begin
        a = 7'(n * 12 + k * 4);
        rd_reg(a, d);
        checks++;
        if (d !== 8'h00) begin
          errors++;
          $display("FAIL reset_reg_%h: got %h expected 00", a, d);
        end
      end
    end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected 00", d); end
    rd_reg(7'h64, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h expected 00", d); end
    rd_reg(7'h7F, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unmapped_7f: got %h expected 00", d); end
  endtask

  task automatic test_ctrl();
    logic [7:0] d;
    wr_reg(7'h00, 8'hFF);
    rd_reg(7'h00, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ctrl0_mask: got %h expected 01", d); end
    wr_reg(7'h04, 8'hAA);
    rd_reg(7'h04, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL period_ro: got %h expected 00", d); end
    wr_reg(7'h00, 8'h00);
    // Simultaneous read and write of CTRL1 returns the pre-write value.
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; adrs = 7'h0C; din = 8'h01;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rdwr_old: got %h expected 00", dout); end
    rd_reg(7'h0C, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL rdwr_new: got %h expected 01", d); end
    wr_reg(7'h0C, 8'h00);
    drain();
  endtask

  task automatic test_capture();
    logic [7:0] d;
    wr_reg(7'h00, 8'h01);
    start_gen(0, 100, 30);
    repeat (250) @(negedge clk);
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL cap_valid: got %h expected 01", d); end
    rd_reg(7'h04, d);
    checks++;
    if (d !== 8'd100) begin errors++; $display("FAIL cap_period0: got %0d expected 100", d); end
    rd_reg(7'h08, d);
    checks++;
    if (d !== 8'd30) begin errors++; $display("FAIL cap_high0: got %0d expected 30", d); end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL cap_valid_clr: got %h expected 00", d); end
    wr_reg(7'h00, 8'h00);
    gen_on[0] = 1'b0;
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    wr_reg(7'h24, 8'h01);
    pulse(3, 5);
    repeat (300) @(negedge clk);
    rd_reg(7'h64, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL ovf_set: got %h expected 08", d); end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_arm_only: got %h expected 00", d); end
    rd_reg(7'h64, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovf_clr: got %h expected 00", d); end
    pulse(3, 5);
    repeat (10) @(negedge clk);
    rd_reg(7'h28, d);
    checks++;
    if (d !== 8'd255) begin errors++; $display("FAIL ovf_period3: got %0d expected 255", d); end
    rd_reg(7'h2C, d);
    checks++;
    if (d !== 8'd5) begin errors++; $display("FAIL ovf_high3: got %0d expected 5", d); end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL ovf_valid3: got %h expected 08", d); end
    wr_reg(7'h24, 8'h00);
    drain();
  endtask

  task automatic test_read_race();
    logic [7:0] d;
    wr_reg(7'h3C, 8'h01);
    // Arming pulse at negedge A, high for 4 cycles.
    pulse(5, 4);
    repeat (20) @(negedge clk);
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL race_armed: got %h expected 00", d); end
    // Second rise at A+27; its capture edge coincides with the VALID read.
    @(negedge clk);
    lvl[5] = 1'b1;
    repeat (3) @(negedge clk);
    rd = 1'b1;
    adrs = 7'h60;
    @(negedge clk);
    rd = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL race_old: got %h expected 00", dout); end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL race_set_wins: got %h expected 20", d); end
    rd_reg(7'h40, d);
    checks++;
    if (d !== 8'd27) begin errors++; $display("FAIL race_period5: got %0d expected 27", d); end
    rd_reg(7'h44, d);
    checks++;
    if (d !== 8'd4) begin errors++; $display("FAIL race_high5: got %0d expected 4", d); end
    wr_reg(7'h3C, 8'h00);
    lvl[5] = 1'b0;
    drain();
  endtask

  task automatic test_enable_gating();
    logic [7:0] d;
    wr_reg(7'h18, 8'h01);
    start_gen(2, 40, 15);
    repeat (150) @(negedge clk);
    rd_reg(7'h1C, d);
    checks++;
    if (d !== 8'd40) begin errors++; $display("FAIL gate_period2: got %0d expected 40", d); end
    rd_reg(7'h20, d);
    checks++;
    if (d !== 8'd15) begin errors++; $display("FAIL gate_high2: got %0d expected 15", d); end
    wr_reg(7'h18, 8'h00);
    drain();
    start_gen(2, 50, 10);
    repeat (200) @(negedge clk);
    rd_reg(7'h1C, d);
    checks++;
    if (d !== 8'd40) begin errors++; $display("FAIL gate_hold_period: got %0d expected 40", d); end
    rd_reg(7'h20, d);
    checks++;
    if (d !== 8'd15) begin errors++; $display("FAIL gate_hold_high: got %0d expected 15", d); end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL gate_hold_valid: got %h expected 00", d); end
    gen_on[2] = 1'b0;
    lvl[2] = 1'b0;
    repeat (5) @(negedge clk);
    wr_reg(7'h18, 8'h01);
    start_gen(2, 50, 10);
    repeat (25) @(negedge clk);
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rearm_valid: got %h expected 00", d); end
    rd_reg(7'h1C, d);
    checks++;
    if (d !== 8'd40) begin errors++; $display("FAIL rearm_period: got %0d expected 40", d); end
    repeat (60) @(negedge clk);
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL reen_valid: got %h expected 04", d); end
    rd_reg(7'h1C, d);
    checks++;
    if (d !== 8'd50) begin errors++; $display("FAIL reen_period2: got %0d expected 50", d); end
    rd_reg(7'h20, d);
    checks++;
    if (d !== 8'd10) begin errors++; $display("FAIL reen_high2: got %0d expected 10", d); end
    wr_reg(7'h18, 8'h00);
    gen_on[2] = 1'b0;
    drain();
  endtask

  task automatic test_all_channels();
    logic [7:0] d;
    logic [6:0] a;
    for (int n = 0; n < 8; n++) begin
      wr_reg(7'(n * 12), 8'h01);
    end
    for (int n = 0; n < 8; n++) begin
      start_gen(n, 20 + n, 5);
    end
    repeat (100) @(negedge clk);
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'hFF) begin errors++; $display("FAIL all_valid: got %h expected ff", d); end
    for (int n = 0; n < 8; n++) begin
      a = 7'(n * 12 + 4);
      rd_reg(a, d);
      checks++;
      if (d !== 8'(20 + n)) begin
        errors++;
        $display("FAIL all_period%0d: got %0d expected %0d", n, d, 20 + n);
      end
      a = 7'(n * 12 + 8);
      rd_reg(a, d);
      checks++;
      if (d !== 8'd5) begin
        errors++;
        $display("FAIL all_high%0d: got %0d expected 5", n, d);
      end
    end
    // Reset pulse in the middle of running measurements.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", dout); end
    repeat (60) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) begin
        a = 7'(n * 12 + k * 4);
        rd_reg(a, d);
        checks++;
        if (d !== 8'h00) begin
          errors++;
          $display("FAIL rst_reg_%h: got %h expected 00", a, d);
        end
      end
    end
    rd_reg(7'h60, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_valid: got %h expected 00", d); end
    rd_reg(7'h64, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rst_ovf: got %h expected 00", d); end
    gen_on = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    din = 8'h00;
    adrs = 7'h00;
    lvl = 8'h00;
    gen_on = 8'h00;
    for (int n = 0; n < 8; n++) begin
      per[n] = 2;
      hi[n] = 1;
      ph[n] = 0;
    end
    test_reset();
    test_ctrl();
    test_capture();
    test_overflow();
    test_read_race();
    test_enable_gating();
    test_all_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
